// File: rtl/local_network_interface_if.sv
// Bundle of PE-side and router-side local-port signals for the network interface.
// The slave modport is the interface block's view; master is the PE/router side.
interface local_network_interface_if;
    logic        pe_tx_valid_i;
    logic [15:0] pe_tx_dest_i;
    logic [15:0] pe_tx_data_i;
    logic        pe_tx_ready_o;
    logic [15:0] noc_data_o;
    logic        noc_valid_o;
    logic        noc_credit_i;
    logic [15:0] noc_data_i;
    logic        noc_valid_i;
    logic        noc_credit_o;
    logic [15:0] pe_rx_data_o;
    logic        pe_rx_valid_o;
    logic        pe_rx_head_o;
    logic        pe_rx_ready_i;
    logic        err_o;

    modport slave (
        input  pe_tx_valid_i, pe_tx_dest_i, pe_tx_data_i,
        input  noc_credit_i, noc_data_i, noc_valid_i, pe_rx_ready_i,
        output pe_tx_ready_o, noc_data_o, noc_valid_o, noc_credit_o,
        output pe_rx_data_o, pe_rx_valid_o, pe_rx_head_o, err_o
    );

    modport master (
        output pe_tx_valid_i, pe_tx_dest_i, pe_tx_data_i,
        output noc_credit_i, noc_data_i, noc_valid_i, pe_rx_ready_i,
        input  pe_tx_ready_o, noc_data_o, noc_valid_o, noc_credit_o,
        input  pe_rx_data_o, pe_rx_valid_o, pe_rx_head_o, err_o
    );
endinterface

// File: rtl/local_network_interface.sv
// PE <-> router local-port network interface: credit-based TX packetizer and
// RX FIFO that returns one credit per flit consumed by the PE.
module local_network_interface #(
    parameter int unsigned PKT_LEN  = 4,
    parameter int unsigned TX_CRED  = 8,
    parameter int unsigned RX_DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    local_network_interface_if.slave  bus
);
    localparam int unsigned CW = $clog2(TX_CRED + 1);
    localparam int unsigned BW = $clog2(PKT_LEN);
    localparam int unsigned AW = $clog2(RX_DEPTH);
    localparam int unsigned NW = AW + 1;
    localparam logic [CW-1:0] CRED_MAX  = CW'(TX_CRED);
    localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_LEN - 1);
    localparam logic [NW-1:0] RX_FULL   = NW'(RX_DEPTH);

    typedef enum logic {IDLE, BODY} state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [CW-1:0] credit_q, credit_d;
    logic          send_c, tx_ready_c, cred_ovf_c;
    logic [15:0]   tx_word_c;
    logic [15:0]   noc_data_q;
    logic          noc_valid_q, noc_credit_q, err_q;

    logic [15:0]   rx_mem [RX_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [NW-1:0] rx_cnt_q;
    logic [BW-1:0] rx_idx_q;
    logic          pop_c, push_c, drop_c, full_c;

    // TX packetizer: header from dest in IDLE, then PKT_LEN-1 body words
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        send_c     = 1'b0;
        tx_ready_c = 1'b0;
        tx_word_c  = bus.pe_tx_dest_i;
        case (state_q)
            IDLE: begin
                if (bus.pe_tx_valid_i && credit_q != '0) begin
                    send_c  = 1'b1;
                    beat_d  = BW'(1);
                    state_d = BODY;
                end
            end
            BODY: begin
                tx_word_c = bus.pe_tx_data_i;
                if (bus.pe_tx_valid_i && credit_q != '0) begin
                    send_c     = 1'b1;
                    tx_ready_c = 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = IDLE;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Credit counter; a return that would exceed the buffer depth is an error
    always_comb begin
        credit_d   = credit_q;
        cred_ovf_c = 1'b0;
        if (bus.noc_credit_i && !send_c) begin
            if (credit_q == CRED_MAX) cred_ovf_c = 1'b1;
            else                      credit_d   = credit_q + CW'(1);
        end else if (send_c && !bus.noc_credit_i) begin
            credit_d = credit_q - CW'(1);
        end
    end

    assign full_c = (rx_cnt_q == RX_FULL);
    assign pop_c  = (rx_cnt_q != '0) && bus.pe_rx_ready_i;
    assign push_c = bus.noc_valid_i && (!full_c || pop_c);
    assign drop_c = bus.noc_valid_i && full_c && !pop_c;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            beat_q       <= '0;
            credit_q     <= CRED_MAX;
            noc_data_q   <= '0;
            noc_valid_q  <= 1'b0;
            noc_credit_q <= 1'b0;
            err_q        <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            rx_cnt_q     <= '0;
            rx_idx_q     <= '0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            credit_q     <= credit_d;
            noc_valid_q  <= send_c;
            noc_credit_q <= pop_c;
            if (send_c) noc_data_q <= tx_word_c;
            if (cred_ovf_c || drop_c) err_q <= 1'b1;
            if (push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
                rx_idx_q <= (rx_idx_q == LAST_BEAT) ? '0 : rx_idx_q + BW'(1);
            end
            if (push_c && !pop_c)      rx_cnt_q <= rx_cnt_q + NW'(1);
            else if (pop_c && !push_c) rx_cnt_q <= rx_cnt_q - NW'(1);
        end
    end

    // FIFO storage needs no reset; occupancy is tracked by rx_cnt_q
    always_ff @(posedge clk) begin
        if (push_c) rx_mem[wr_ptr_q] <= bus.noc_data_i;
    end

    assign bus.pe_tx_ready_o = tx_ready_c;
    assign bus.noc_data_o    = noc_data_q;
    assign bus.noc_valid_o   = noc_valid_q;
    assign bus.noc_credit_o  = noc_credit_q;
    assign bus.pe_rx_data_o  = rx_mem[rd_ptr_q];
    assign bus.pe_rx_valid_o = (rx_cnt_q != '0);
    assign bus.pe_rx_head_o  = (rx_idx_q == '0);
    assign bus.err_o         = err_q;
endmodule

// File: tb/tb_local_network_interface.sv
// Directed bench for local_network_interface: TX table vectors plus hand-written
// credit, RX FIFO and mid-packet reset sequences.
module tb_local_network_interface;
    logic clk;
    logic reset;
    int   tests;
    int   fails;

    local_network_interface_if bus ();

    local_network_interface #(
        .PKT_LEN (4),
        .TX_CRED (8),
        .RX_DEPTH(8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [15:0] dest;
        logic [15:0] data;
        logic        cred;
        logic        exp_ready;
        logic        exp_valid;
        logic [15:0] exp_data;
        logic        chk_cred;
        logic [3:0]  exp_cred;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.pe_tx_valid_i = 1'b0;
        bus.pe_tx_dest_i  = '0;
        bus.pe_tx_data_i  = '0;
        bus.noc_credit_i  = 1'b0;
        bus.noc_data_i    = '0;
        bus.noc_valid_i   = 1'b0;
        bus.pe_rx_ready_i = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle_inputs();
        step();
        step();
        reset = 1'b1;
    endtask

    initial begin
        int cnt;
        logic [15:0] last;
        tests = 0;
        fails = 0;
        reset = 1'b0;
        idle_inputs();
        // 0102 header, then A,B,C back-to-back; second packet exercises gap + simultaneous credit
        vecs[0]  = '{1'b1, 16'h0102, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0102, 1'b0, 4'd0};
        vecs[1]  = '{1'b1, 16'h0000, 16'hAAAA, 1'b0, 1'b1, 1'b1, 16'hAAAA, 1'b0, 4'd0};
        vecs[2]  = '{1'b1, 16'h0000, 16'hBBBB, 1'b0, 1'b1, 1'b1, 16'hBBBB, 1'b0, 4'd0};
        vecs[3]  = '{1'b1, 16'h0000, 16'hCCCC, 1'b0, 1'b1, 1'b1, 16'hCCCC, 1'b1, 4'd4};
        vecs[4]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 4'd4};
        vecs[5]  = '{1'b1, 16'h0304, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0304, 1'b1, 4'd4};
        vecs[6]  = '{1'b1, 16'h0000, 16'h1111, 1'b0, 1'b1, 1'b1, 16'h1111, 1'b1, 4'd3};
        vecs[7]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 4'd3};
        vecs[8]  = '{1'b1, 16'h0000, 16'h2222, 1'b0, 1'b1, 1'b1, 16'h2222, 1'b1, 4'd2};
        vecs[9]  = '{1'b1, 16'h0000, 16'h3333, 1'b1, 1'b1, 1'b1, 16'h3333, 1'b1, 4'd2};
        vecs[10] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 4'd2};

        // reset state
        step();
        step();
        chk("rst_noc_valid", 32'(bus.noc_valid_o), 32'd0);
        chk("rst_noc_data", 32'(bus.noc_data_o), 32'd0);
        chk("rst_noc_credit", 32'(bus.noc_credit_o), 32'd0);
        chk("rst_err", 32'(bus.err_o), 32'd0);
        chk("rst_rx_valid", 32'(bus.pe_rx_valid_o), 32'd0);
        chk("rst_credit", 32'(dut.credit_q), 32'd8);
        reset = 1'b1;

        // T1/T3 table
        for (int i = 0; i < 11; i++) begin
            bus.pe_tx_valid_i = vecs[i].valid;
            bus.pe_tx_dest_i  = vecs[i].dest;
            bus.pe_tx_data_i  = vecs[i].data;
            bus.noc_credit_i  = vecs[i].cred;
            #1;
            chk($sformatf("vec%0d_ready", i), 32'(bus.pe_tx_ready_o), 32'(vecs[i].exp_ready));
            step();
            chk($sformatf("vec%0d_valid", i), 32'(bus.noc_valid_o), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid)
                chk($sformatf("vec%0d_data", i), 32'(bus.noc_data_o), 32'(vecs[i].exp_data));
            if (vecs[i].chk_cred)
                chk($sformatf("vec%0d_credit", i), 32'(dut.credit_q), 32'(vecs[i].exp_cred));
        end
        idle_inputs();
        chk("t1_err_clear", 32'(bus.err_o), 32'd0);

        // T2 credit exhaustion: exactly 8 flits from full credit
        do_reset();
        bus.pe_tx_valid_i = 1'b1;
        bus.pe_tx_dest_i  = 16'h0505;
        bus.pe_tx_data_i  = 16'h7777;
        cnt = 0;
        for (int i = 0; i < 14; i++) begin
            step();
            if (bus.noc_valid_o) cnt++;
        end
        chk("t2_flits_sent", 32'(cnt), 32'd8);
        chk("t2_ready_stall", 32'(bus.pe_tx_ready_o), 32'd0);
        chk("t2_valid_stall", 32'(bus.noc_valid_o), 32'd0);
        bus.noc_credit_i = 1'b1;
        step();
        bus.noc_credit_i = 1'b0;
        cnt  = 0;
        last = '0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (bus.noc_valid_o) begin
                cnt++;
                last = bus.noc_data_o;
            end
        end
        chk("t2_one_released", 32'(cnt), 32'd1);
        chk("t2_released_hdr", 32'(last), 32'h0505);
        idle_inputs();

        // T3 credit overflow at full count
        do_reset();
        bus.noc_credit_i = 1'b1;
        step();
        bus.noc_credit_i = 1'b0;
        chk("t3_credit_hold", 32'(dut.credit_q), 32'd8);
        chk("t3_err_set", 32'(bus.err_o), 32'd1);

        // T4 RX fill, drop, drain
        do_reset();
        for (int i = 0; i < 8; i++) begin
            bus.noc_valid_i = 1'b1;
            bus.noc_data_i  = 16'(16'h1000 + i);
            step();
            chk("t4_no_credit_fill", 32'(bus.noc_credit_o), 32'd0);
        end
        bus.noc_valid_i = 1'b0;
        chk("t4_rx_valid", 32'(bus.pe_rx_valid_o), 32'd1);
        chk("t4_full", 32'(dut.rx_cnt_q), 32'd8);
        chk("t4_err_before", 32'(bus.err_o), 32'd0);
        bus.noc_valid_i = 1'b1;
        bus.noc_data_i  = 16'hDEAD;
        step();
        bus.noc_valid_i = 1'b0;
        chk("t4_err_drop", 32'(bus.err_o), 32'd1);
        chk("t4_still_full", 32'(dut.rx_cnt_q), 32'd8);
        bus.pe_rx_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("t4_pop%0d_data", i), 32'(bus.pe_rx_data_o), 32'(16'h1000 + i));
            chk($sformatf("t4_pop%0d_head", i), 32'(bus.pe_rx_head_o), 32'((i % 4) == 0));
            step();
            chk($sformatf("t4_pop%0d_credit", i), 32'(bus.noc_credit_o), 32'd1);
        end
        step();
        chk("t4_credit_end", 32'(bus.noc_credit_o), 32'd0);
        chk("t4_empty", 32'(bus.pe_rx_valid_o), 32'd0);
        idle_inputs();

        // T5 push+pop on full FIFO
        do_reset();
        for (int i = 0; i < 8; i++) begin
            bus.noc_valid_i = 1'b1;
            bus.noc_data_i  = 16'(16'h2000 + i);
            step();
        end
        bus.noc_data_i    = 16'h2008;
        bus.pe_rx_ready_i = 1'b1;
        #1;
        chk("t5_head", 32'(bus.pe_rx_data_o), 32'h2000);
        step();
        bus.noc_valid_i = 1'b0;
        chk("t5_no_err", 32'(bus.err_o), 32'd0);
        chk("t5_count", 32'(dut.rx_cnt_q), 32'd8);
        for (int i = 1; i < 9; i++) begin
            #1;
            chk($sformatf("t5_pop%0d", i), 32'(bus.pe_rx_data_o), 32'(16'h2000 + i));
            step();
        end
        chk("t5_empty", 32'(bus.pe_rx_valid_o), 32'd0);
        idle_inputs();

        // T6 reset mid-BODY at beat 2
        do_reset();
        bus.pe_tx_valid_i = 1'b1;
        bus.pe_tx_dest_i  = 16'h0A0A;
        step();
        bus.pe_tx_data_i = 16'h0B01;
        step();
        chk("t6_body_out", 32'(bus.noc_data_o), 32'h0B01);
        bus.pe_tx_data_i = 16'h0B02;
        reset = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(bus.noc_valid_o), 32'd0);
        chk("t6_rst_data", 32'(bus.noc_data_o), 32'd0);
        chk("t6_rst_credit_o", 32'(bus.noc_credit_o), 32'd0);
        step();
        step();
        chk("t6_hold_valid", 32'(bus.noc_valid_o), 32'd0);
        reset = 1'b1;
        chk("t6_credit_reset", 32'(dut.credit_q), 32'd8);
        bus.pe_tx_dest_i = 16'h0C0C;
        bus.pe_tx_data_i = 16'h0B03;
        step();
        chk("t6_hdr_valid", 32'(bus.noc_valid_o), 32'd1);
        chk("t6_hdr_data", 32'(bus.noc_data_o), 32'h0C0C);
        chk("t6_credit_after", 32'(dut.credit_q), 32'd7);
        idle_inputs();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
